// File: rtl/debug_pkg.sv
// debug_pkg: shared constants, FSM encoding and BCD sizing for the debug-variable overlay.
package debug_pkg;
    localparam logic [3:0] SIGN_NEG = 4'ha;
    localparam logic [3:0] SIGN_BLANK = 4'hf;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_WRITE} state_t;
    function automatic int bcd_digits(input int seq_len);
        return seq_len / 3 + 1;
    endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration, add 3 to every nibble >= 5 then shift in one bit.
module bcd_dabble_step #(
    parameter int BCD_DIGITS = 6
) (
    input  logic [BCD_DIGITS*4-1:0] bcd,
    input  logic                    shift_in,
    output logic [BCD_DIGITS*4-1:0] bcd_next,
    output logic                    carry
);
    logic [BCD_DIGITS*4-1:0] adj;
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        assign adj[g*4 +: 4] = bcd[g*4 +: 4] >= 4'd5 ? bcd[g*4 +: 4] + 4'd3 : bcd[g*4 +: 4];
    end
    assign bcd_next = {adj[BCD_DIGITS*4-2:0], shift_in};
    assign carry = adj[BCD_DIGITS*4-1];
endmodule

// File: rtl/debug_var_scheduler.sv
// debug_var_scheduler: per-frame sweep that converts each watched variable to sign-magnitude BCD
// and commits it atomically into a digit table read asynchronously by the renderer.
module debug_var_scheduler
    import debug_pkg::*;
#(
    parameter int NUM_VARS = 4,
    parameter int SEQ_LEN = 16,
    parameter int SEQ_DIGIT = SEQ_LEN / 4 + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic [NUM_VARS*SEQ_LEN-1:0] vars,
    input  logic [NUM_VARS-1:0]         hold,
    input  logic [$clog2(NUM_VARS)-1:0] rd_idx,
    output logic [SEQ_DIGIT*4-1:0]      rd_digits,
    output logic                        rd_ovf,
    output logic                        busy,
    output logic                        sweep_done,
    output logic                        overrun
);
    localparam int IDX_W = $clog2(NUM_VARS);
    localparam int CNT_W = $clog2(SEQ_LEN);
    localparam int BCD_DIGITS = bcd_digits(SEQ_LEN);
    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int MAG_DIGITS = SEQ_DIGIT - 1;
    localparam int ENTRY_W = SEQ_DIGIT * 4 + 1;
    localparam logic [ENTRY_W-1:0] ENTRY_RST = {1'b0, SIGN_BLANK, {(MAG_DIGITS*4){1'b0}}};

    state_t state, state_n;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [SEQ_LEN-1:0] mag, cur;
    logic [BCD_W-1:0] bcd, bcd_n;
    logic [ENTRY_W-1:0] table_q [NUM_VARS];
    logic neg, ovf_c, carry, ovf, last;

    assign cur = vars[int'(idx)*SEQ_LEN +: SEQ_LEN];
    assign last = idx == IDX_W'(NUM_VARS - 1);
    // A carry out of the top digit is folded in so overflow can never be masked by truncation.
    assign ovf = ovf_c | (|bcd[BCD_W-1:MAG_DIGITS*4]);
    assign busy = state != S_IDLE;
    assign rd_digits = table_q[rd_idx][ENTRY_W-2:0];
    assign rd_ovf = table_q[rd_idx][ENTRY_W-1];

    bcd_dabble_step #(.BCD_DIGITS(BCD_DIGITS)) u_step (
        .bcd(bcd),
        .shift_in(mag[SEQ_LEN-1]),
        .bcd_next(bcd_n),
        .carry(carry)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = frame_start ? S_LOAD : S_IDLE;
            S_LOAD:  state_n = hold[idx] ? (last ? S_IDLE : S_LOAD) : S_CONV;
            S_CONV:  state_n = cnt == CNT_W'(SEQ_LEN - 1) ? S_WRITE : S_CONV;
            S_WRITE: state_n = last ? S_IDLE : S_LOAD;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx <= '0;
            cnt <= '0;
            mag <= '0;
            bcd <= '0;
            neg <= 1'b0;
            ovf_c <= 1'b0;
            sweep_done <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_VARS; i++) table_q[i] <= ENTRY_RST;
        end else begin
            state <= state_n;
            sweep_done <= state != S_IDLE && state_n == S_IDLE;
            overrun <= frame_start && state != S_IDLE;
            if (state == S_IDLE && frame_start) idx <= '0;
            if ((state == S_LOAD && hold[idx]) || state == S_WRITE) idx <= last ? '0 : idx + 1'b1;
            if (state == S_LOAD) begin
                neg <= cur[SEQ_LEN-1];
                mag <= cur[SEQ_LEN-1] ? ~cur + 1'b1 : cur;
                bcd <= '0;
                cnt <= '0;
                ovf_c <= 1'b0;
            end
            if (state == S_CONV) begin
                bcd <= bcd_n;
                mag <= mag << 1;
                cnt <= cnt + 1'b1;
                ovf_c <= ovf_c | carry;
            end
            if (state == S_WRITE)
                table_q[idx] <= {ovf, neg ? SIGN_NEG : SIGN_BLANK,
                                 ovf ? {MAG_DIGITS{4'h9}} : bcd[MAG_DIGITS*4-1:0]};
        end
    end
endmodule

// File: tb/tb_debug_var_scheduler.sv
// tb_debug_var_scheduler: directed scenario tests for the debug-variable sweep scheduler.
module tb_debug_var_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic [63:0] vars = '0;
    logic [3:0] hold = '0;
    logic [1:0] rd_idx = '0;
    logic [19:0] rd_digits;
    logic rd_ovf, busy, sweep_done, overrun;
    int checks = 0;
    int errors = 0;

    debug_var_scheduler dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .vars(vars), .hold(hold),
        .rd_idx(rd_idx), .rd_digits(rd_digits), .rd_ovf(rd_ovf), .busy(busy),
        .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Pulses frame_start and returns the cycle offset of sweep_done plus busy violations.
    task automatic run_sweep(output int done_at, output int busy_bad);
        done_at = -1;
        busy_bad = 0;
        frame_start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (sweep_done) begin
                done_at = k;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            checks++;
            if ({rd_ovf, rd_digits} !== 21'h0F0000) begin
                errors++;
                $display("FAIL reset entry%0d got %h exp %h", i, {rd_ovf, rd_digits}, 21'h0F0000);
            end
        end
        checks++;
        if ({busy, sweep_done, overrun} !== 3'b000) begin
            errors++;
            $display("FAIL reset flags busy/done/ovr got %b exp 000", {busy, sweep_done, overrun});
        end
    endtask

    task automatic test_basic();
        logic [20:0] exp [4] = '{21'h0F9999, 21'h0F1234, 21'h0A0001, 21'h0F0000};
        int done_at, busy_bad;
        vars = {16'h0000, 16'hFFFF, 16'h04D2, 16'h270F};
        run_sweep(done_at, busy_bad);
        checks++;
        if (done_at !== 73) begin errors++; $display("FAIL basic sweep_done cycle got %0d exp 73", done_at); end
        checks++;
        if (busy_bad !== 0) begin errors++; $display("FAIL basic busy window bad cycles got %0d exp 0", busy_bad); end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            checks++;
            if ({rd_ovf, rd_digits} !== exp[i]) begin
                errors++;
                $display("FAIL basic entry%0d got %h exp %h", i, {rd_ovf, rd_digits}, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (sweep_done !== 1'b0) begin errors++; $display("FAIL basic sweep_done width got 1 exp 0"); end
    endtask

    task automatic test_overflow();
        logic [20:0] exp [4] = '{21'h1F9999, 21'h1A9999, 21'h0A9999, 21'h0F0010};
        int done_at, busy_bad;
        vars = {16'h000A, 16'hD8F1, 16'h8000, 16'h7FFF};
        run_sweep(done_at, busy_bad);
        checks++;
        if (done_at !== 73) begin errors++; $display("FAIL ovf sweep_done cycle got %0d exp 73", done_at); end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            checks++;
            if ({rd_ovf, rd_digits} !== exp[i]) begin
                errors++;
                $display("FAIL ovf entry%0d got %h exp %h", i, {rd_ovf, rd_digits}, exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [20:0] exp [4] = '{21'h0F0005, 21'h1A9999, 21'h0A9999, 21'h0F0010};
        int done_at, busy_bad;
        vars = {16'h000A, 16'hD8F1, 16'h1111, 16'h0005};
        hold = 4'b0010;
        run_sweep(done_at, busy_bad);
        checks++;
        if (done_at !== 56) begin errors++; $display("FAIL hold1 sweep_done cycle got %0d exp 56", done_at); end
        checks++;
        if (busy_bad !== 0) begin errors++; $display("FAIL hold1 busy window bad cycles got %0d exp 0", busy_bad); end
        hold = 4'hF;
        vars = {16'h0001, 16'h0002, 16'h0003, 16'h0007};
        run_sweep(done_at, busy_bad);
        checks++;
        if (done_at !== 5) begin errors++; $display("FAIL holdall sweep_done cycle got %0d exp 5", done_at); end
        hold = 4'h0;
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            checks++;
            if ({rd_ovf, rd_digits} !== exp[i]) begin
                errors++;
                $display("FAIL hold entry%0d got %h exp %h", i, {rd_ovf, rd_digits}, exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int done_at = -1;
        vars = {16'h0000, 16'hFFFF, 16'h04D2, 16'h270F};
        frame_start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            frame_start = k == 10;
            if (k == 5) vars[15:0] = 16'h0001;
            if (k == 11) begin
                checks++;
                if (overrun !== 1'b1) begin errors++; $display("FAIL overrun pulse t0+11 got %b exp 1", overrun); end
            end
            if (k == 12) begin
                checks++;
                if (overrun !== 1'b0) begin errors++; $display("FAIL overrun width t0+12 got %b exp 0", overrun); end
            end
            if (sweep_done) begin done_at = k; break; end
        end
        checks++;
        if (done_at !== 73) begin errors++; $display("FAIL overrun sweep_done cycle got %0d exp 73", done_at); end
        rd_idx = 2'd0;
        #1;
        checks++;
        if ({rd_ovf, rd_digits} !== 21'h0F9999) begin
            errors++;
            $display("FAIL overrun entry0 snapshot got %h exp %h", {rd_ovf, rd_digits}, 21'h0F9999);
        end
    endtask

    task automatic test_back_to_back();
        int done_at = -1;
        int k = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        while (!sweep_done && k < 200) begin @(negedge clk); k++; end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if ({busy, overrun} !== 2'b10) begin
            errors++;
            $display("FAIL b2b accept busy/overrun got %b exp 10", {busy, overrun});
        end
        for (int j = 2; j <= 200; j++) begin
            @(negedge clk);
            if (sweep_done) begin done_at = j; break; end
        end
        checks++;
        if (done_at !== 73) begin errors++; $display("FAIL b2b sweep_done cycle got %0d exp 73", done_at); end
        rd_idx = 2'd0;
        #1;
        checks++;
        if ({rd_ovf, rd_digits} !== 21'h0F0001) begin
            errors++;
            $display("FAIL b2b entry0 got %h exp %h", {rd_ovf, rd_digits}, 21'h0F0001);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        frame_start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (k == 30) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy got %b exp 0", busy); end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            checks++;
            if ({rd_ovf, rd_digits} !== 21'h0F0000) begin
                errors++;
                $display("FAIL rstmid entry%0d got %h exp %h", i, {rd_ovf, rd_digits}, 21'h0F0000);
            end
        end
        if (sweep_done || overrun) pulses++;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (sweep_done || overrun || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL rstmid stray activity cycles got %0d exp 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_hold();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debug_var_scheduler.md
# debug_var_scheduler

Sequential front end for the on-screen debug-variable overlay. Once per frame it sweeps NUM_VARS watched variables and snapshots each one. It converts each value to sign-magnitude BCD with an iterative one-bit-per-cycle double-dabble, then writes the result atomically into a per-variable digit table. The VGA renderer reads the table by index and feeds the codes to the digit font ROM; this replaces the per-variable combinational BCD trees.

## Interface
- NUM_VARS, 4, number of watched variables (≥2)
- SEQ_LEN, 16, variable width in bits, two's complement, multiple of 4
- SEQ_DIGIT, SEQ_LEN/4+1, digit slots per variable; top slot is the sign
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse that starts a sweep
- vars  in  NUM_VARS*SEQ_LEN  variable k at [k*SEQ_LEN +: SEQ_LEN]
- hold  in  NUM_VARS  1 = freeze entry k; it is skipped during the sweep
- rd_idx  in  clog2(NUM_VARS)  renderer read select
- rd_digits  out  SEQ_DIGIT*4  entry rd_idx; digit j at [j*4 +: 4], sign at top nibble
- rd_ovf  out  1  overflow flag of entry rd_idx
- busy  out  1  high whenever the FSM is not in IDLE
- sweep_done  out  1  one-cycle pulse at the end of a sweep
- overrun  out  1  one-cycle pulse when frame_start is ignored

## Operation
- FSM states are IDLE, LOAD, CONV and WRITE. Index idx runs 0..NUM_VARS-1.
- IDLE: on frame_start, set idx=0 and go to LOAD.
- LOAD, hold[idx]=1:
  - No table change.
  - Go to LOAD with idx+1, or to IDLE if idx is the last index.
- LOAD, hold[idx]=0:
  - Snapshot vars[idx].
  - sign = MSB; mag = sign ? ~v+1 : v, held unsigned.
  - Clear the BCD register; go to CONV.
- CONV: runs exactly SEQ_LEN cycles. Each cycle:
  - Add 3 to every BCD nibble that is ≥5.
  - Shift {bcd, mag} left by one bit, MSB first.
- BCD register width is BCD_DIGITS = SEQ_LEN/3+1 digits, enough for 2^(SEQ_LEN-1).
- Overflow: if any digit at or above position MAG_DIGITS = SEQ_DIGIT-1 is nonzero, the entry's magnitude digits become all 9, and ovf=1.
- WRITE: write the whole entry in one cycle.
  - Magnitude digits take their converted (or saturated) values.
  - Sign nibble is 4'ha when negative, 4'hf (blank) otherwise.
  - Then go to LOAD with idx+1, or to IDLE after the last index.
- Changes on vars after LOAD do not affect the conversion in flight.
- rd_digits and rd_ovf are a combinational mux of the registered table. The renderer therefore never sees a half-written entry.
- frame_start arriving in any state other than IDLE is ignored, and overrun pulses the next cycle.

## Timing
- Reset values:
  - state IDLE, idx 0.
  - busy 0, sweep_done 0, overrun 0.
  - Every table entry = magnitude 0, sign 4'hf (16-bit: 20'hF0000), ovf 0.
- With frame_start sampled at t0:
  - LOAD(0) at t0+1.
  - A converted variable takes SEQ_LEN+2 cycles; a held variable takes 1 cycle.
  - The entry is visible on rd_digits the cycle after its WRITE.
  - sweep_done is high on the first IDLE cycle: t0 + (NUM_VARS−H)(SEQ_LEN+2) + H + 1, with H = number of held variables.
  - busy is high from t0+1 through the cycle before sweep_done.
- frame_start in the same cycle sweep_done is high is accepted, because the FSM is in IDLE.
- rst mid-sweep: the next cycle is IDLE, the table is at reset values, and no sweep_done or overrun is produced.
- hold is sampled only in LOAD, for the current index.

## Structure
- Package debug_pkg holds:
  - SIGN_NEG = 4'ha and SIGN_BLANK = 4'hf (the font ROM renders 4'hf as blank).
  - The FSM state encoding.
  - The BCD_DIGITS derivation function.
- One sub-module, bcd_dabble_step: purely combinational add-3 followed by a one-bit shift, parameterised by BCD_DIGITS.
- The table is a register array of NUM_VARS × (SEQ_DIGIT*4+1) bits. No block RAM, so reads are asynchronous.

## Test plan
Defaults NUM_VARS=4, SEQ_LEN=16.
- Reset → all rd_idx read 20'hF0000, rd_ovf 0; busy=0, sweep_done=0.
- vars = {0x0000, 0xFFFF, 0x04D2, 0x270F} (var3..var0), frame_start at t0 →
  - entries 0..3 = F9999, F1234, A0001, F0000.
  - sweep_done exactly at t0+73; busy high t0+1..t0+72.
- var0..var3 = 0x7FFF, 0x8000, 0xD8F1, 0x000A →
  - 0x7FFF: F9999, ovf=1.
  - 0x8000: A9999, ovf=1.
  - 0xD8F1: A9999, ovf=0.
  - 0x000A: F0010, ovf=0.
- hold=4'b0010, var1 changed → entry1 unchanged, sweep_done at t0+56. With hold=4'hF → sweep_done at t0+5.
- Extra frame_start at t0+10 plus a var0 change at t0+5 →
  - overrun pulses at t0+11.
  - entry0 reflects the t0+1 snapshot; sweep_done still at t0+73.
- rst at t0+30 → at t0+31 busy=0 and all entries F0000; no sweep_done pulse.
